// File: rtl/stage_pkg.sv
// Shared types and helpers for the stage sequencer: state encoding, ROM field
// indices, score width and the saturating score adder.
package stage_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    PASSED,
    FAILED,
    DONE
  } stage_state_t;

  localparam int unsigned FIELD_X    = 0;
  localparam int unsigned FIELD_Y    = 1;
  localparam int unsigned FIELD_TYPE = 2;

  localparam int unsigned SCORE_W = 16;

  // Width helper that never collapses to zero bits for tiny parameter values.
  function automatic int unsigned widthOf(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned stageTarget(input int unsigned base,
                                              input int unsigned step,
                                              input int unsigned lvl);
    return base + lvl * step;
  endfunction

  function automatic logic [SCORE_W-1:0] satAdd(input logic [SCORE_W-1:0] a,
                                                input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/stage_timer.sv
// Loadable seconds down-counter for one stage; expire strobes on the tick
// that takes the count from 1 to 0.
module stage_timer
  import stage_pkg::*;
#(
  parameter int unsigned STAGE_TIME = 60,
  parameter int unsigned TIME_W     = 6
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              enable,
  input  logic              tick,
  input  logic              load,
  input  logic              clear,
  output logic [TIME_W-1:0] timeLeft,
  output logic              expire
);

  assign expire = enable && tick && (timeLeft == TIME_W'(1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timeLeft <= '0;
    end else if (clear) begin
      timeLeft <= '0;
    end else if (load) begin
      timeLeft <= TIME_W'(STAGE_TIME);
    end else if (enable && tick && (timeLeft != '0)) begin
      timeLeft <= timeLeft - 1'b1;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Stage sequencer: loads each level's objects from ROM, runs the timed play
// phase with grab scoring, and walks through pass/fail/retry/done.
module stage_sequencer
  import stage_pkg::*;
#(
  parameter int unsigned NUM_LEVELS  = 4,
  parameter int unsigned NUM_OBJECTS = 20,
  parameter int unsigned STAGE_TIME  = 60,
  parameter int unsigned BASE_TARGET = 100,
  parameter int unsigned TARGET_STEP = 50,
  parameter int unsigned OBJ_W       = 9,
  localparam int unsigned IDX_W  = widthOf(NUM_OBJECTS),
  localparam int unsigned ADDR_W = widthOf(NUM_LEVELS * NUM_OBJECTS * 3),
  localparam int unsigned LVL_W  = widthOf(NUM_LEVELS),
  localparam int unsigned TIME_W = widthOf(STAGE_TIME + 1)
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         start,
  input  logic                         oneSecPulse,
  input  logic                         grabValid,
  input  logic [IDX_W-1:0]             grabIndex,
  input  logic [SCORE_W-1:0]           grabValue,
  output logic [ADDR_W-1:0]            romAddr,
  input  logic [OBJ_W-1:0]             romData,
  output logic [NUM_OBJECTS*OBJ_W-1:0] objX,
  output logic [NUM_OBJECTS*OBJ_W-1:0] objY,
  output logic [NUM_OBJECTS*OBJ_W-1:0] objType,
  output logic [NUM_OBJECTS-1:0]       objAlive,
  output logic [LVL_W-1:0]             levelIdx,
  output logic [TIME_W-1:0]            timeLeft,
  output logic [SCORE_W-1:0]           score,
  output logic                         busy,
  output logic                         playing,
  output logic                         stagePassed,
  output logic                         stageFailed,
  output logic                         lastLevelEnded
);

  localparam int unsigned WORDS = NUM_OBJECTS * 3;
  localparam int unsigned CNT_W = widthOf(WORDS + 1);

  stage_state_t state, nextState;

  logic [CNT_W-1:0]       loadCnt;
  logic [IDX_W-1:0]       capObj;
  logic [1:0]             capField;
  logic [SCORE_W-1:0]     entryScore;
  logic [NUM_OBJECTS-1:0] grabMask;
  logic [NUM_OBJECTS-1:0] aliveAfter;
  logic                   grabHit;
  logic [SCORE_W-1:0]     scoreAfter;
  logic [LVL_W-1:0]       loadLevel;
  logic                   enterLoad;
  logic                   loadDone;
  logic                   stageEnd;
  logic                   stageWin;
  logic                   resetScore;
  logic                   restoreScore;
  logic                   timerExpire;

  // Decoding the index against every legal object means out-of-range indices
  // simply match nothing and the grab falls away.
  always_comb begin
    grabMask = '0;
    for (int unsigned i = 0; i < NUM_OBJECTS; i++) begin
      if (grabIndex == IDX_W'(i)) grabMask[i] = 1'b1;
    end
    grabHit    = (state == PLAY) && grabValid && (|(grabMask & objAlive));
    aliveAfter = grabHit ? (objAlive & ~grabMask) : objAlive;
    scoreAfter = grabHit ? satAdd(score, grabValue) : score;
  end

  always_comb begin
    nextState    = state;
    enterLoad    = 1'b0;
    loadLevel    = levelIdx;
    resetScore   = 1'b0;
    restoreScore = 1'b0;
    loadDone     = 1'b0;
    stageEnd     = 1'b0;
    stageWin     = 32'(scoreAfter) >= stageTarget(BASE_TARGET, TARGET_STEP, 32'(levelIdx));
    case (state)
      IDLE: begin
        if (start) begin
          nextState  = LOAD;
          enterLoad  = 1'b1;
          loadLevel  = '0;
          resetScore = 1'b1;
        end
      end
      LOAD: begin
        if (loadCnt == CNT_W'(WORDS)) begin
          nextState = PLAY;
          loadDone  = 1'b1;
        end
      end
      PLAY: begin
        if (timerExpire || (aliveAfter == '0)) begin
          stageEnd  = 1'b1;
          nextState = stageWin ? PASSED : FAILED;
        end
      end
      PASSED: begin
        if (start) begin
          if (32'(levelIdx) < NUM_LEVELS - 1) begin
            nextState = LOAD;
            enterLoad = 1'b1;
            loadLevel = levelIdx + 1'b1;
          end else begin
            nextState = DONE;
          end
        end
      end
      FAILED: begin
        if (start) begin
          nextState    = LOAD;
          enterLoad    = 1'b1;
          restoreScore = 1'b1;
        end
      end
      DONE: begin
        if (start) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  stage_timer #(
    .STAGE_TIME(STAGE_TIME),
    .TIME_W    (TIME_W)
  ) uTimer (
    .clk     (clk),
    .resetN  (resetN),
    .enable  (state == PLAY),
    .tick    (oneSecPulse),
    .load    (loadDone),
    .clear   (stageEnd),
    .timeLeft(timeLeft),
    .expire  (timerExpire)
  );

  // ROM has one cycle of latency: cycle c presents address c and captures
  // word c-1, so the capture counters trail the address by one cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      loadCnt    <= '0;
      capObj     <= '0;
      capField   <= '0;
      romAddr    <= '0;
      levelIdx   <= '0;
      score      <= '0;
      entryScore <= '0;
      objAlive   <= '0;
      objX       <= '0;
      objY       <= '0;
      objType    <= '0;
    end else if (enterLoad) begin
      levelIdx <= loadLevel;
      loadCnt  <= '0;
      capObj   <= '0;
      capField <= '0;
      romAddr  <= ADDR_W'(32'(loadLevel) * WORDS);
      objAlive <= '0;
      if (resetScore)        score <= '0;
      else if (restoreScore) score <= entryScore;
    end else if (state == LOAD) begin
      loadCnt <= loadCnt + 1'b1;
      romAddr <= (loadCnt < CNT_W'(WORDS - 1)) ? romAddr + 1'b1 : '0;
      if (loadCnt != '0) begin
        if (capField == 2'(FIELD_X))      objX[capObj*OBJ_W +: OBJ_W]    <= romData;
        else if (capField == 2'(FIELD_Y)) objY[capObj*OBJ_W +: OBJ_W]    <= romData;
        else                              objType[capObj*OBJ_W +: OBJ_W] <= romData;
        if (capField == 2'(FIELD_TYPE)) begin
          capField <= '0;
          capObj   <= capObj + 1'b1;
        end else begin
          capField <= capField + 1'b1;
        end
      end
      if (loadDone) begin
        objAlive   <= '1;
        entryScore <= score;
      end
    end else if (state == PLAY) begin
      objAlive <= aliveAfter;
      score    <= scoreAfter;
    end
  end

  always_comb begin
    busy           = (state == LOAD);
    playing        = (state == PLAY);
    stagePassed    = (state == PASSED);
    stageFailed    = (state == FAILED);
    lastLevelEnded = (state == DONE);
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer with two levels of two objects; ROM
// word w holds w+1.
module tb_stage_sequencer;

  localparam int unsigned K_LOAD  = 0;
  localparam int unsigned K_END   = 1;
  localparam int unsigned K_DONE  = 2;
  localparam int unsigned K_PROBE = 3;

  localparam logic [4:0] F_NONE   = 5'b00000;
  localparam logic [4:0] F_PLAY   = 5'b01000;
  localparam logic [4:0] F_PASSED = 5'b00100;
  localparam logic [4:0] F_FAILED = 5'b00010;
  localparam logic [4:0] F_DONE   = 5'b00001;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic        oneSecPulse = 1'b0;
  logic        grabValid = 1'b0;
  logic [0:0]  grabIndex = '0;
  logic [15:0] grabValue = '0;
  logic [3:0]  romAddr;
  logic [8:0]  romData = '0;
  logic [17:0] objX, objY, objType;
  logic [1:0]  objAlive;
  logic [0:0]  levelIdx;
  logic [5:0]  timeLeft;
  logic [15:0] score;
  logic        busy, playing, stagePassed, stageFailed, lastLevelEnded;
  logic        probe = 1'b0;

  logic [8:0] rom [0:15];

  typedef struct {
    int unsigned kind;
    int unsigned busyLen;
    logic [17:0] x, y, t;
    logic [1:0]  alive;
    int unsigned tLeft;
    int unsigned sc;
    int unsigned lvl;
    logic [4:0]  flags;
    bit          full;
  } exp_t;

  exp_t q[$];
  int unsigned nChecks = 0;
  int unsigned nFails  = 0;

  stage_sequencer #(
    .NUM_LEVELS (2),
    .NUM_OBJECTS(2),
    .STAGE_TIME (60),
    .BASE_TARGET(100),
    .TARGET_STEP(50),
    .OBJ_W      (9)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .start         (start),
    .oneSecPulse   (oneSecPulse),
    .grabValid     (grabValid),
    .grabIndex     (grabIndex),
    .grabValue     (grabValue),
    .romAddr       (romAddr),
    .romData       (romData),
    .objX          (objX),
    .objY          (objY),
    .objType       (objType),
    .objAlive      (objAlive),
    .levelIdx      (levelIdx),
    .timeLeft      (timeLeft),
    .score         (score),
    .busy          (busy),
    .playing       (playing),
    .stagePassed   (stagePassed),
    .stageFailed   (stageFailed),
    .lastLevelEnded(lastLevelEnded)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = (i < 12) ? 9'(i + 1) : 9'd0;
  end

  always @(posedge clk) romData <= rom[romAddr];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mkBlank(input int unsigned kind);
    exp_t e;
    e.kind = kind; e.busyLen = 0; e.x = '0; e.y = '0; e.t = '0; e.alive = '0;
    e.tLeft = 0; e.sc = 0; e.lvl = 0; e.flags = '0; e.full = 1'b0;
    return e;
  endfunction

  // Objects of level lvl as stored in the ROM image (word w = w+1).
  function automatic exp_t withObjs(input exp_t e0, input int unsigned lvl);
    exp_t e;
    e = e0;
    e.x = {9'(lvl * 6 + 4), 9'(lvl * 6 + 1)};
    e.y = {9'(lvl * 6 + 5), 9'(lvl * 6 + 2)};
    e.t = {9'(lvl * 6 + 6), 9'(lvl * 6 + 3)};
    return e;
  endfunction

  function automatic exp_t mkLoad(input int unsigned lvl, input int unsigned sc);
    exp_t e;
    e = withObjs(mkBlank(K_LOAD), lvl);
    e.busyLen = 7; e.alive = 2'b11; e.tLeft = 60; e.sc = sc; e.lvl = lvl;
    return e;
  endfunction

  function automatic exp_t mkEnd(input logic [4:0] flags, input int unsigned sc,
                                 input int unsigned lvl);
    exp_t e;
    e = mkBlank(K_END);
    e.flags = flags; e.sc = sc; e.lvl = lvl; e.tLeft = 0;
    return e;
  endfunction

  function automatic exp_t mkProbe(input logic [4:0] flags, input bit full,
                                   input int unsigned sc, input int unsigned tl,
                                   input logic [1:0] alive, input int unsigned lvl,
                                   input bit objs);
    exp_t e;
    e = mkBlank(K_PROBE);
    if (objs) e = withObjs(e, lvl);
    e.flags = flags; e.full = full; e.sc = sc; e.tLeft = tl; e.alive = alive; e.lvl = lvl;
    return e;
  endfunction

  // Monitor: pops an expectation whenever the DUT presents a visible event.
  logic        prevBusy = 1'b0;
  logic        prevEnd  = 1'b0;
  logic        prevLast = 1'b0;
  int unsigned busyCnt  = 0;

  always @(negedge clk) begin
    exp_t        e;
    int unsigned kind;
    bit          ev;
    logic [4:0]  flagsNow;
    ev = 1'b1;
    kind = K_PROBE;
    flagsNow = {busy, playing, stagePassed, stageFailed, lastLevelEnded};
    if (busy && !prevBusy) busyCnt = 1;
    else if (busy)         busyCnt++;
    if (probe)                                          kind = K_PROBE;
    else if (prevBusy && !busy && playing)              kind = K_LOAD;
    else if ((stagePassed || stageFailed) && !prevEnd)  kind = K_END;
    else if (lastLevelEnded && !prevLast)               kind = K_DONE;
    else                                                ev = 1'b0;
    if (ev) begin
      if (q.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
      end else begin
        e = q.pop_front();
        chk("event_kind", kind, e.kind);
        if (kind == e.kind) begin
          case (kind)
            K_LOAD: begin
              chk("load_busy_cycles", busyCnt, e.busyLen);
              chk("load_objX", objX, e.x);
              chk("load_objY", objY, e.y);
              chk("load_objType", objType, e.t);
              chk("load_objAlive", objAlive, e.alive);
              chk("load_timeLeft", timeLeft, e.tLeft);
              chk("load_score", score, e.sc);
              chk("load_levelIdx", levelIdx, e.lvl);
            end
            K_END: begin
              chk("end_flags", flagsNow, e.flags);
              chk("end_score", score, e.sc);
              chk("end_timeLeft", timeLeft, e.tLeft);
              chk("end_levelIdx", levelIdx, e.lvl);
            end
            K_DONE: begin
              chk("done_flags", flagsNow, F_DONE);
              chk("done_levelIdx", levelIdx, e.lvl);
              chk("done_score", score, e.sc);
            end
            default: begin
              chk("probe_flags", flagsNow, e.flags);
              chk("probe_romAddr", romAddr, 0);
              if (e.full) begin
                chk("probe_score", score, e.sc);
                chk("probe_timeLeft", timeLeft, e.tLeft);
                chk("probe_objAlive", objAlive, e.alive);
                chk("probe_levelIdx", levelIdx, e.lvl);
                chk("probe_objX", objX, e.x);
                chk("probe_objY", objY, e.y);
                chk("probe_objType", objType, e.t);
              end
            end
          endcase
        end
      end
    end
    prevBusy = busy;
    prevEnd  = stagePassed || stageFailed;
    prevLast = lastLevelEnded;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doProbe(input exp_t e);
    q.push_back(e);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic pulse();
    oneSecPulse = 1'b1;
    tick();
    oneSecPulse = 1'b0;
    tick();
  endtask

  task automatic pulses(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) pulse();
  endtask

  task automatic startPulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic grab(input logic [0:0] idx, input logic [15:0] val);
    grabValid = 1'b1;
    grabIndex = idx;
    grabValue = val;
    tick();
    grabValid = 1'b0;
  endtask

  task automatic waitPlaying();
    for (int i = 0; i < 40 && !playing; i++) tick();
    chk("load_timeout_playing", playing, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(); tick();
    doProbe(mkProbe(F_NONE, 1'b1, 0, 0, 2'b00, 0, 1'b0));
    resetN = 1'b1;
    tick();

    // First load of level 0
    q.push_back(mkLoad(0, 0));
    startPulse();
    waitPlaying();

    // Grab, repeat grab on dead object, partial countdown, expiry -> pass
    grab(1'b1, 16'd120);
    doProbe(mkProbe(F_PLAY, 1'b1, 120, 60, 2'b01, 0, 1'b1));
    grab(1'b1, 16'd50);
    doProbe(mkProbe(F_PLAY, 1'b1, 120, 60, 2'b01, 0, 1'b1));
    pulses(10);
    doProbe(mkProbe(F_PLAY, 1'b1, 120, 50, 2'b01, 0, 1'b1));
    pulses(49);
    q.push_back(mkEnd(F_PASSED, 120, 0));
    pulse();
    pulse();
    doProbe(mkProbe(F_PASSED, 1'b1, 120, 0, 2'b01, 0, 1'b1));

    // Level 1: grab coincident with the final pulse reaches target 150
    q.push_back(mkLoad(1, 120));
    startPulse();
    waitPlaying();
    pulses(59);
    q.push_back(mkEnd(F_PASSED, 150, 1));
    grabValid = 1'b1; grabIndex = 1'b0; grabValue = 16'd30; oneSecPulse = 1'b1;
    tick();
    grabValid = 1'b0; oneSecPulse = 1'b0;
    tick();

    // Last level ended, then back to IDLE
    begin
      exp_t d;
      d = mkBlank(K_DONE);
      d.lvl = 1; d.sc = 150;
      q.push_back(d);
    end
    startPulse();
    tick();
    startPulse();
    doProbe(mkProbe(F_NONE, 1'b0, 0, 0, 2'b00, 0, 1'b0));

    // Fail level 0 with 40 points, retry restores entry score
    q.push_back(mkLoad(0, 0));
    startPulse();
    waitPlaying();
    grab(1'b0, 16'd40);
    doProbe(mkProbe(F_PLAY, 1'b1, 40, 60, 2'b10, 0, 1'b1));
    q.push_back(mkEnd(F_FAILED, 40, 0));
    pulses(60);
    q.push_back(mkLoad(0, 0));
    startPulse();
    waitPlaying();

    // Saturation, and clearing every object ends the stage at once
    grab(1'b0, 16'hFFF0);
    doProbe(mkProbe(F_PLAY, 1'b1, 16'hFFF0, 60, 2'b10, 0, 1'b1));
    q.push_back(mkEnd(F_PASSED, 16'hFFFF, 0));
    grab(1'b1, 16'd100);
    tick();

    // Reset asserted while level 1 word 4 is being addressed
    startPulse();
    tick(); tick(); tick(); tick();
    chk("romAddr_word4", romAddr, 10);
    resetN = 1'b0;
    tick();
    doProbe(mkProbe(F_NONE, 1'b1, 0, 0, 2'b00, 0, 1'b0));
    resetN = 1'b1;
    tick(); tick();

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
